// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline control logic.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [1:0] RET_DRAIN = 2'd2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ctrlState_t;

    // Instructions whose result register is only known after the memory stage.
    function automatic logic isMemLoad(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the five-stage Y86-64 pipeline:
// stall/bubble generation, ret drain, halt shutdown and perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode_d,
    input  logic [3:0]       srcA_d,
    input  logic [3:0]       srcB_d,
    input  logic [3:0]       icode_e,
    input  logic [3:0]       dstM_e,
    input  logic             cnd_e,
    input  logic [2:0]       stat_m,
    input  logic [2:0]       stat_w,
    output logic             f_stall,
    output logic             d_stall,
    output logic             w_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrlState_t state;
    logic [1:0] retCnt;
    logic       loadUse;
    logic       mispredict;
    logic       retPending;
    logic       retD;
    logic       wExcept;
    logic       mExcept;
    logic       runCycle;

    // Hazard detection from the current stage contents.
    always_comb begin
        retD       = (icode_d == I_RET);
        loadUse    = isMemLoad(icode_e) && (dstM_e != REG_NONE) &&
                     ((dstM_e == srcA_d) || (dstM_e == srcB_d));
        mispredict = (icode_e == I_JXX) && !cnd_e;
        retPending = (retD && !mispredict) || (retCnt != 2'd0);
        mExcept    = (stat_m != STAT_AOK);
        wExcept    = (stat_w != STAT_AOK);
        runCycle   = !rst && (state == RUN);
    end

    // Pipeline register controls; reset flushes, HALTED freezes everything.
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else if (state == HALTED) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            w_stall  = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else begin
            f_stall  = loadUse || retPending;
            d_stall  = loadUse;
            d_bubble = mispredict || (retPending && !loadUse);
            e_bubble = mispredict || loadUse;
            m_bubble = mExcept || wExcept;
            w_stall  = wExcept;
            set_cc   = (icode_e == I_OPQ) && !mExcept && !wExcept;
        end
    end

    // A RET only starts draining once it actually leaves D.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            retCnt    <= 2'd0;
            halt_stat <= 3'd0;
        end else if (state == RUN) begin
            if (retD && !loadUse && !mispredict) begin
                retCnt <= RET_DRAIN;
            end else if (retCnt != 2'd0) begin
                retCnt <= retCnt - 2'd1;
            end
            if (wExcept) begin
                state     <= HALTED;
                halt_stat <= stat_w;
            end
        end
    end

    assign halted = (state == HALTED);

    sat_counter #(.W(CNT_W)) uCycCnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (runCycle),
        .count (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (runCycle && f_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) uBubbleCnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (runCycle && (d_bubble || e_bubble)),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a behavioural model; a CNT_W=4 copy exercises counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode_d, srcA_d, srcB_d, icode_e, dstM_e;
    logic        cnd_e;
    logic [2:0]  stat_m, stat_w;

    logic        f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc, halted;
    logic [2:0]  halt_stat;
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;

    logic        sF, sD, sW, sDb, sEb, sMb, sCc, sHalted;
    logic [2:0]  sHaltStat;
    logic [3:0]  sCyc, sStall, sBubble;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .icode_d(icode_d), .srcA_d(srcA_d), .srcB_d(srcB_d),
        .icode_e(icode_e), .dstM_e(dstM_e), .cnd_e(cnd_e), .stat_m(stat_m), .stat_w(stat_w),
        .f_stall(f_stall), .d_stall(d_stall), .w_stall(w_stall), .d_bubble(d_bubble),
        .e_bubble(e_bubble), .m_bubble(m_bubble), .set_cc(set_cc), .halted(halted),
        .halt_stat(halt_stat), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .icode_d(icode_d), .srcA_d(srcA_d), .srcB_d(srcB_d),
        .icode_e(icode_e), .dstM_e(dstM_e), .cnd_e(cnd_e), .stat_m(stat_m), .stat_w(stat_w),
        .f_stall(sF), .d_stall(sD), .w_stall(sW), .d_bubble(sDb),
        .e_bubble(sEb), .m_bubble(sMb), .set_cc(sCc), .halted(sHalted),
        .halt_stat(sHaltStat), .cyc_cnt(sCyc), .stall_cnt(sStall), .bubble_cnt(sBubble)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit     mValid    = 0;
    bit     mHalted   = 0;
    int     mHaltStat = 0;
    int     mRetLeft  = 0;   // further F-stall cycles owed to a RET that left D
    longint mCyc = 0, mStall = 0, mBub = 0;

    function automatic bit mLu();
        return (icode_e == 4'h5 || icode_e == 4'hB) && dstM_e != 4'hF &&
               (dstM_e == srcA_d || dstM_e == srcB_d);
    endfunction

    function automatic bit mMp();
        return icode_e == 4'h7 && cnd_e == 1'b0;
    endfunction

    function automatic bit mRp();
        return (icode_d == 4'h9 && !mMp()) || mRetLeft > 0;
    endfunction

    function automatic longint satTo(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc}
    function automatic logic [6:0] expCtrl();
        bit lu, mp, rp, mBad, wBad;
        if (rst) return 7'b000_1110;
        if (mHalted) return 7'b111_0110;
        lu = mLu(); mp = mMp(); rp = mRp();
        mBad = stat_m != 3'd1;
        wBad = stat_w != 3'd1;
        return {lu || rp, lu, wBad, mp || (rp && !lu), mp || lu, mBad || wBad,
                icode_e == 4'h6 && !mBad && !wBad};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mValid <= 1; mHalted <= 0; mHaltStat <= 0; mRetLeft <= 0;
            mCyc <= 0; mStall <= 0; mBub <= 0;
        end else if (mValid && !mHalted) begin
            mCyc <= mCyc + 1;
            if (mLu() || mRp()) mStall <= mStall + 1;
            if (mLu() || mMp() || mRp()) mBub <= mBub + 1;
            if (icode_d == 4'h9 && !mLu() && !mMp()) mRetLeft <= 2;
            else mRetLeft <= (mRetLeft > 0) ? mRetLeft - 1 : 0;
            if (stat_w != 3'd1) begin
                mHalted <= 1;
                mHaltStat <= int'(stat_w);
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [6:0] e;
        e = expCtrl();
        check("ctrl", {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc}, e);
        check("ctrl_sat", {sF, sD, sW, sDb, sEb, sMb, sCc}, e);
        if (mValid) begin
            check("halted", halted, mHalted);
            check("halt_stat", halt_stat, mHaltStat);
            check("cyc_cnt", cyc_cnt, satTo(mCyc, 32));
            check("stall_cnt", stall_cnt, satTo(mStall, 32));
            check("bubble_cnt", bubble_cnt, satTo(mBub, 32));
            check("sat_halted", {sHalted, sHaltStat}, {mHalted, 3'(mHaltStat)});
            check("sat_cyc", sCyc, satTo(mCyc, 4));
            check("sat_stall", sStall, satTo(mStall, 4));
            check("sat_bubble", sBubble, satTo(mBub, 4));
        end
    end

    // ---------------- stimulus ----------------
    task automatic setNop();
        icode_d = 4'h1; srcA_d = 4'hF; srcB_d = 4'hF;
        icode_e = 4'h1; dstM_e = 4'hF; cnd_e = 1'b1;
        stat_m = 3'd1; stat_w = 3'd1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        nextCycle();
        setNop();
        rst = 1'b1;
        @(negedge clk);
        check("rst_stalls", {f_stall, d_stall, w_stall}, 3'b000);
        check("rst_bubbles", {d_bubble, e_bubble, m_bubble, set_cc}, 4'b1110);
        nextCycle();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] randReg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'hF : 4'(r);
    endfunction

    function automatic logic [2:0] randStat(input int oneIn);
        return ($urandom_range(1, oneIn) == 1) ? 3'($urandom_range(2, 4)) : 3'd1;
    endfunction

    initial begin
        rst = 1'b1;
        setNop();
        @(negedge clk);

        // Load-use: one stall cycle, stall_cnt 0 -> 1.
        doReset();
        icode_e = 4'h5; dstM_e = 4'h3; srcA_d = 4'h3;
        @(negedge clk);
        check("lu_ctrl", {f_stall, d_stall, e_bubble, d_bubble}, 4'b1110);
        check("lu_cnt0", stall_cnt, 32'd0);
        nextCycle(); setNop();
        @(negedge clk);
        check("lu_after", f_stall, 1'b0);
        check("lu_cnt1", stall_cnt, 32'd1);

        // RET: three stall+bubble cycles.
        doReset();
        icode_d = 4'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ret_drain", {f_stall, d_bubble}, 2'b11);
            nextCycle(); setNop();
        end
        @(negedge clk);
        check("ret_done", {f_stall, d_bubble}, 2'b00);
        check("ret_bub", bubble_cnt, 32'd3);

        // Mispredict squashes a RET in D.
        doReset();
        icode_e = 4'h7; cnd_e = 1'b0; icode_d = 4'h9;
        @(negedge clk);
        check("mp_ctrl", {f_stall, d_bubble, e_bubble}, 3'b011);
        nextCycle(); setNop();
        @(negedge clk);
        check("mp_after", {f_stall, d_bubble, e_bubble}, 3'b000);

        // Load-use on %rsp with RET in D: 4 F-stall cycles in total.
        doReset();
        icode_e = 4'h5; dstM_e = 4'h4; icode_d = 4'h9; srcA_d = 4'h4; srcB_d = 4'h4;
        @(negedge clk);
        check("comb_lu", {f_stall, d_stall, d_bubble}, 3'b110);
        nextCycle(); setNop(); icode_d = 4'h9; srcA_d = 4'h4; srcB_d = 4'h4;
        @(negedge clk);
        check("comb_ret", {f_stall, d_stall, d_bubble}, 3'b101);
        nextCycle(); setNop();
        repeat (2) begin
            @(negedge clk);
            check("comb_drain", f_stall, 1'b1);
            nextCycle(); setNop();
        end
        @(negedge clk);
        check("comb_done", f_stall, 1'b0);
        check("comb_stalls", stall_cnt, 32'd4);

        // Halt sequence and recovery through reset.
        doReset();
        stat_m = 3'd2; icode_e = 4'h6;
        @(negedge clk);
        check("hlt_m", {m_bubble, set_cc, halted}, 3'b100);
        nextCycle(); stat_w = 3'd2;
        @(negedge clk);
        check("hlt_w", {w_stall, halted}, 2'b10);
        nextCycle(); setNop();
        @(negedge clk);
        check("hlt_state", {halted, halt_stat}, {1'b1, 3'd2});
        check("hlt_ctrl", {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc}, 7'b111_0110);
        check("hlt_cyc", cyc_cnt, 32'd2);
        repeat (3) nextCycle();
        @(negedge clk);
        check("hlt_freeze", cyc_cnt, 32'd2);
        doReset();
        @(negedge clk);
        check("hlt_clear", {halted, cyc_cnt}, {1'b0, 32'd0});

        // Saturation of the 4-bit copy.
        doReset();
        repeat (20) nextCycle();
        @(negedge clk);
        check("sat_cyc15", sCyc, 4'd15);
        check("cyc20", cyc_cnt, 32'd20);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            nextCycle();
            icode_d = 4'($urandom_range(0, 11));
            srcA_d  = randReg();
            srcB_d  = randReg();
            icode_e = 4'($urandom_range(0, 11));
            dstM_e  = randReg();
            cnd_e   = 1'($urandom_range(0, 1));
            stat_m  = randStat(30);
            stat_w  = randStat(80);
            rst     = ($urandom_range(1, 200) == 1) || (mHalted && $urandom_range(1, 6) == 1);
        end
        nextCycle();
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the five-stage Y86-64 pipeline. Each cycle it inspects the decode, execute, memory and write-back stage contents and drives the stall and bubble controls of the F, D, E, M and W pipeline registers. It tracks `ret` drain cycles and the halt/exception shutdown with internal state, and keeps saturating performance counters. It sits beside the datapath, and its outputs go directly to the pipeline registers' load/flush controls.

## Interface
- `CNT_W`, 32, width of each performance counter
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `icode_d`  in  4  instruction code in D register
- `srcA_d`, `srcB_d`  in  4 each  decode source register IDs; 0xF = none
- `icode_e`  in  4  instruction code in E register
- `dstM_e`  in  4  memory destination register in E; 0xF = none
- `cnd_e`  in  1  branch condition computed in execute
- `stat_m`, `stat_w`  in  3 each  status in M and W stages: AOK=1, HLT=2, ADR=3, INS=4
- `f_stall`, `d_stall`, `w_stall`  out  1 each  hold the register
- `d_bubble`, `e_bubble`, `m_bubble`  out  1 each  load NOP/AOK into the register
- `set_cc`  out  1  condition-code write enable
- `halted`  out  1  pipeline permanently stopped
- `halt_stat`  out  3  stat_w latched on entry to HALTED
- `cyc_cnt`, `stall_cnt`, `bubble_cnt`  out  CNT_W each  performance counters

## Operation
- Icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- Load-use hazard (`lu`): `icode_e` is MRMOVQ or POPQ, `dstM_e` != 0xF, and `dstM_e` equals `srcA_d` or `srcB_d`.
- Mispredict (`mp`): `icode_e`==JXX and `cnd_e`==0. Branches are predicted taken.
- Ret pending (`rp`): (`icode_d`==RET and not `mp`) or `ret_cnt` != 0.
- `ret_cnt` (2 bits): loads 2 when `icode_d`==RET and neither `lu` nor `mp` is active. Otherwise it decrements to 0 and holds there.
- FSM has two states, RUN and HALTED.
  - RUN -> HALTED when `stat_w` != AOK.
  - HALTED is left only by `rst`.
- Outputs in RUN:
  - `f_stall` = `lu` | `rp`
  - `d_stall` = `lu`
  - `d_bubble` = `mp` | (`rp` & ~`lu`)
  - `e_bubble` = `mp` | `lu`
  - `m_bubble` = (`stat_m` != AOK) | (`stat_w` != AOK)
  - `w_stall` = (`stat_w` != AOK)
  - `set_cc` = (`icode_e`==OPQ) & `stat_m`==AOK & `stat_w`==AOK
- Outputs in HALTED: `f_stall`=`d_stall`=`w_stall`=1, `e_bubble`=`m_bubble`=1, `d_bubble`=0, `set_cc`=0, `halted`=1.
- Counters:
  - `cyc_cnt` increments every cycle in RUN.
  - `stall_cnt` increments on RUN cycles with `f_stall`.
  - `bubble_cnt` increments on RUN cycles with `d_bubble` | `e_bubble`.
  - All counters saturate at 2^CNT_W-1 and freeze in HALTED.

## Timing
- Control outputs are combinational from the current inputs and registered state, so they act at the same rising edge. `halted`, `halt_stat` and the counters are registered.
- While `rst`=1:
  - all stalls are 0;
  - `d_bubble`, `e_bubble` and `m_bubble` are 1, which flushes the pipeline;
  - `set_cc` is 0.
- On the first edge with `rst`=1: state becomes RUN, `ret_cnt`=0, `halted`=0, `halt_stat`=0 and all counters are 0.
- A `rst` asserted while HALTED or during a ret drain clears everything on that edge.
- `lu` + `rp`: `lu` wins. The RET is held in D and `ret_cnt` does not load. D gets stall, not bubble.
- `mp` + RET in D: the RET is squashed (D bubble) and `ret_cnt` does not load.
- A RET in D stalls F for 3 cycles in total: the D cycle, then `ret_cnt`=2, then `ret_cnt`=1.
- `halted` rises on the edge after `stat_w` first shows non-AOK. `halt_stat` captures `stat_w` on that same edge.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants;
  - stat codes AOK/HLT/ADR/INS;
  - REG_NONE=4'hF;
  - FSM state enum.
- One sub-module, `sat_counter` (CNT_W-bit, inc enable, sync clear, saturating), is instantiated three times.

## Test plan
- Load-use: MRMOVQ in E with `dstM_e`=3 and `srcA_d`=3 -> `f_stall`=`d_stall`=`e_bubble`=1 and `d_bubble`=0 for exactly 1 cycle. `stall_cnt` goes 0->1.
- Ret: `icode_d`=9 for one cycle, then NOPs -> `f_stall`=`d_bubble`=1 for 3 consecutive cycles, then 0. `bubble_cnt`=3.
- Mispredict: `icode_e`=7 with `cnd_e`=0 and RET in D -> `d_bubble`=`e_bubble`=1 for 1 cycle, with no following ret stall cycles.
- Combined: MRMOVQ to %rsp in E while RET in D reads %rsp -> cycle 1 is a load-use stall. The RET then gets its 3 ret-stall cycles, for 4 total `f_stall` cycles.
- Halt:
  - `stat_m`=2 -> `m_bubble`=1 and `set_cc`=0 even with OPQ in E.
  - Next cycle `stat_w`=2 -> `halted`=1 and `halt_stat`=2 after the edge. All stalls stay asserted and counters freeze.
  - Asserting `rst` returns to RUN with counters at 0.
- Saturation: with CNT_W=4, run 20 cycles -> `cyc_cnt` holds at 15.
